// File: rtl/pool_0_pkg.sv
// Shared constants and types for the 2x2 max-pool block.
// POOL_N results per frame, DATA_W bits per channel sample.
package pool_0_pkg;

  localparam int         DATA_W = 18;
  localparam logic [7:0] POOL_N = 8'd169;
  localparam int         RAM_D  = 256;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_ISSUE = 1'b1
  } rd_state_t;

  function automatic logic [DATA_W-1:0] umax(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/pool_ram.sv
// 256 x DATA_W simple dual-port RAM, registered read.
// Ports: clk, rst_n, we/waddr/wdata, re/raddr, rdata.
module pool_ram
  import pool_0_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [7:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [7:0]        raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [RAM_D];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset so outputs start at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pool_0.sv
// 2x2 max-pool of two 26x26 channels into 13x13 RAM, then readout.
// Ports: clk, rst_n, tx_done, din_*, bsy_in, bsy_out, rdy, dout_*, done.
module pool_0
  import pool_0_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_done,
  input  logic              din_vld,
  input  logic [DATA_W-1:0] din_0,
  input  logic [DATA_W-1:0] din_1,
  input  logic              bsy_in,
  output logic              bsy_out,
  output logic              rdy,
  output logic              dout_vld,
  output logic [DATA_W-1:0] dout_0,
  output logic [DATA_W-1:0] dout_1,
  output logic              done
);

  logic [1:0]        cnt_4;
  logic [DATA_W-1:0] max_0;
  logic [DATA_W-1:0] max_1;
  logic [DATA_W-1:0] nxt_0;
  logic [DATA_W-1:0] nxt_1;
  logic [7:0]        addr_wr;
  logic [7:0]        addr_rd;
  rd_state_t         state;
  logic              full;
  logic              take;
  logic              wr_en;
  logic              rd_en;

  assign full  = (addr_wr == POOL_N);
  assign take  = din_vld & ~full & ~tx_done;
  assign wr_en = take & (cnt_4 == 2'd3);
  assign rd_en = (state == R_ISSUE) & ~tx_done;

  // First sample of a window loads directly; ties keep the stored max.
  assign nxt_0 = (cnt_4 == 2'd0) ? din_0 : umax(max_0, din_0);
  assign nxt_1 = (cnt_4 == 2'd0) ? din_1 : umax(max_1, din_1);

  // Registered addresses keep reads strictly behind completed writes.
  assign rdy  = (addr_rd < addr_wr);
  assign done = (addr_rd == POOL_N);

  // Busy when full, or when the open window's write fills the frame.
  assign bsy_out = full |
                   ((cnt_4 != 2'd0) & (addr_wr == POOL_N - 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_4    <= '0;
      max_0    <= '0;
      max_1    <= '0;
      addr_wr  <= '0;
      addr_rd  <= '0;
      state    <= R_IDLE;
      dout_vld <= 1'b0;
    end else if (tx_done) begin
      cnt_4    <= '0;
      max_0    <= '0;
      max_1    <= '0;
      addr_wr  <= '0;
      addr_rd  <= '0;
      state    <= R_IDLE;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= rd_en;
      if (take) begin
        cnt_4 <= cnt_4 + 2'd1;
        max_0 <= nxt_0;
        max_1 <= nxt_1;
      end
      if (wr_en) addr_wr <= addr_wr + 8'd1;
      unique case (state)
        R_IDLE: begin
          if (rdy && !bsy_in) state <= R_ISSUE;
        end
        R_ISSUE: begin
          addr_rd <= addr_rd + 8'd1;
          state   <= R_IDLE;
        end
        default: state <= R_IDLE;
      endcase
    end
  end

  pool_ram u_ram_0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (addr_wr),
    .wdata (nxt_0),
    .re    (rd_en),
    .raddr (addr_rd),
    .rdata (dout_0)
  );

  pool_ram u_ram_1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (addr_wr),
    .wdata (nxt_1),
    .re    (rd_en),
    .raddr (addr_rd),
    .rdata (dout_1)
  );

endmodule

// File: doc/pool_0.md
POOL_0 -- requirements
Module: pool_0

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 tx_done  input  1  frame-complete pulse; synchronously clears all counters and state.
REQ-004 din_vld  input  1  one sample of a 2x2 window present on din_0/din_1 this cycle.
REQ-005 din_0, din_1  input  18 each  unsigned post-ReLU conv outputs, channels 0/1.
REQ-006 bsy_in  input  1  downstream busy; blocks read issue.
REQ-007 bsy_out  output  1  to upstream; high = do not start a new window.
REQ-008 rdy  output  1  pooled data available (addr_rd < addr_wr).
REQ-009 dout_vld  output  1  dout_0/dout_1 valid this cycle.
REQ-010 dout_0, dout_1  output  18 each  pooled maxima, channels 0/1.
REQ-011 done  output  1  all 169 pooled results read out for the frame.

Function
REQ-012 Block SHALL perform 2x2 max-pooling of a 26x26 map per channel into 13x13 (169 results), raster order.
REQ-013 Window samples SHALL arrive as four din_vld pulses, gaps allowed; cnt_4 (2 bits) counts accepted samples.
REQ-014 On din_vld with cnt_4==0, max_0/max_1 SHALL load din_0/din_1; otherwise load max(max_x, din_x), unsigned compare.
REQ-015 On din_vld with cnt_4==3, block SHALL write max(max_x, din_x) to RAM at addr_wr in the same cycle, then addr_wr += 1, cnt_4 -> 0.
REQ-016 Ties SHALL keep the stored value; equal values produce identical output.
REQ-017 addr_wr SHALL be 8 bits, saturate at 169; din_vld while addr_wr==169 SHALL be ignored.
REQ-018 bsy_out SHALL be 1 when addr_wr==169, or when a window is in progress (cnt_4!=0) and the write would land on 169; else 0.
REQ-019 Read FSM states: R_IDLE, R_ISSUE. R_IDLE -> R_ISSUE when rdy && !bsy_in; R_ISSUE drives RAM read at addr_rd, addr_rd += 1, returns to R_IDLE.
REQ-020 RAM read latency SHALL be 1 cycle: dout_vld=1 cycle after R_ISSUE, data = RAM[addr_rd issued].
REQ-021 Maximum read throughput SHALL be one result per 2 cycles; bsy_in asserted in R_IDLE SHALL hold the FSM there.
REQ-022 Simultaneous write and read of the same address SHALL be impossible by construction (rdy uses registered addr_wr).
REQ-023 done SHALL be 1 when addr_rd==169, held until tx_done or reset.
REQ-024 tx_done SHALL take priority over din_vld and read issue in the same cycle: addr_wr, addr_rd, cnt_4, max_x -> 0, FSM -> R_IDLE, dout_vld -> 0.

Reset
REQ-025 rst_n low SHALL asynchronously force addr_wr=0, addr_rd=0, cnt_4=0, max_0=max_1=0, state R_IDLE.
REQ-026 Outputs after reset: bsy_out=0, rdy=0, dout_vld=0, dout_0=dout_1=0, done=0.
REQ-027 Reset mid-window SHALL discard partial maxima; RAM contents need not be cleared.

Structure
REQ-028 Package SHALL hold POOL_N=169, DATA_W=18, and read-state enum typedef.
REQ-029 Storage SHALL be sub-module pool_ram (256x18, 1 write port, 1 registered read port), instantiated once per channel.
REQ-030 Datapath compare, counters and FSM SHALL reside in pool_0; no other sub-modules.

Verification
REQ-031 Window {5,9,3,7} ch0, {0,0,0,0} ch1 -> RAM[0]=9/0; rdy rises next cycle; read gives dout_0=9, dout_1=0, dout_vld one cycle after issue.
REQ-032 din_vld with 2-cycle gaps, values {0x3FFFF,1,2,3} -> result 0x3FFFF (unsigned max, no sign misread).
REQ-033 Stream 169 windows, bsy_in=0 -> bsy_out=1 after 169th write, 170th window ignored, 169 dout_vld pulses, done=1.
REQ-034 bsy_in held high 10 cycles with rdy=1 -> no dout_vld; release -> reads resume at same addr_rd, none skipped.
REQ-035 tx_done coincident with 4th din_vld -> no write, addr_wr=0, rdy=0 next cycle.
REQ-036 rst_n asserted after 2 samples -> all outputs 0 immediately; fresh window {1,2,3,4} after release -> result 4.
